// File: rtl/i2c_target_if.sv
// i2c_target_if: open-drain I2C pins plus the local byte handoff of the target
interface i2c_target_if;
    logic SCL;
    wire SDA;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rd_req;
    logic busy;
    // models the board pull-up resistor on the open-drain data line
    pullup (SDA);
    modport slave (input SCL, inout SDA, input tx_data, output rx_data, output rx_valid, output rd_req, output busy);
    modport master (output SCL, inout SDA, output tx_data, input rx_data, input rx_valid, input rd_req, input busy);
endinterface

// File: rtl/i2c_target.sv
// i2c_target: fixed-address I2C responder handing written bytes out and fetching read bytes from local logic
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input logic clk,
    input logic rst,
    i2c_target_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP} state_t;
    state_t state, state_n;
    logic [1:0] scl_s, sda_s;
    logic scl_d, sda_d, scl_q, sda_q;
    logic scl_rise, scl_fall, start, stop;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n, rx_data_n;
    logic rw, rw_n, oe, oe_n, ack, ack_n, rx_valid_n, rd_req_n, load;
    assign scl_q = scl_s[1];
    assign sda_q = sda_s[1];
    assign scl_rise = scl_q && !scl_d;
    assign scl_fall = !scl_q && scl_d;
    assign start = scl_q && sda_d && !sda_q;
    assign stop = scl_q && !sda_d && sda_q;
    assign bus.busy = state != IDLE;
    // reset releases the line combinationally so an in-flight ACK cannot linger
    assign bus.SDA = (oe && !rst) ? 1'b0 : 1'bz;
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            shreg <= '0;
            rw <= 1'b0;
            oe <= 1'b0;
            ack <= 1'b0;
            bus.rx_data <= '0;
            bus.rx_valid <= 1'b0;
            bus.rd_req <= 1'b0;
        end else begin
            scl_s <= {scl_s[0], bus.SCL};
            sda_s <= {sda_s[0], bus.SDA};
            scl_d <= scl_q;
            sda_d <= sda_q;
            state <= state_n;
            cnt <= cnt_n;
            shreg <= shreg_n;
            rw <= rw_n;
            oe <= oe_n;
            ack <= ack_n;
            bus.rx_data <= rx_data_n;
            bus.rx_valid <= rx_valid_n;
            bus.rd_req <= rd_req_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        shreg_n = shreg;
        rw_n = rw;
        oe_n = oe;
        ack_n = ack;
        rx_data_n = bus.rx_data;
        rx_valid_n = 1'b0;
        rd_req_n = 1'b0;
        load = 1'b0;
        if (start) begin
            state_n = ADDR;
            cnt_n = '0;
            oe_n = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            oe_n = 1'b0;
        end else if (scl_rise) begin
            case (state)
                ADDR, WRITE: begin
                    shreg_n = {shreg[6:0], sda_q};
                    cnt_n = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (state == WRITE) begin
                            rx_data_n = shreg_n;
                            rx_valid_n = 1'b1;
                            state_n = WRITE_ACK;
                        end else if (shreg[6:0] == TARGET_ADDR) begin
                            rw_n = sda_q;
                            rd_req_n = sda_q;
                            state_n = ADDR_ACK;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                READ_ACK: begin
                    ack_n = !sda_q;
                    rd_req_n = !sda_q;
                    state_n = sda_q ? WAIT_STOP : READ_ACK;
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                // oe doubles as the "ACK already driven" flag for the 9th clock
                ADDR_ACK, WRITE_ACK: begin
                    if (!oe) oe_n = 1'b1;
                    else if (state == ADDR_ACK && rw) load = 1'b1;
                    else begin
                        oe_n = 1'b0;
                        state_n = WRITE;
                    end
                end
                READ: begin
                    if (cnt == 3'd0) begin
                        oe_n = 1'b0;
                        ack_n = 1'b0;
                        state_n = READ_ACK;
                    end else begin
                        oe_n = !shreg[7];
                        shreg_n = {shreg[6:0], 1'b0};
                        cnt_n = cnt + 3'd1;
                    end
                end
                READ_ACK: load = ack;
                default: ;
            endcase
            if (load) begin
                oe_n = !bus.tx_data[7];
                shreg_n = {bus.tx_data[6:0], 1'b0};
                cnt_n = 3'd1;
                ack_n = 1'b0;
                state_n = READ;
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-master transactions against i2c_target with hand-computed expectations
module tb_i2c_target;
    localparam int Q = 80;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_low = 1'b0;
    logic sda_line;
    int total = 0;
    int bad = 0;
    int rx_cnt = 0;
    int rd_cnt = 0;
    logic [7:0] tx_seq [4] = '{8'h3C, 8'h81, 8'h7E, 8'h00};
    i2c_target_if bus ();
    i2c_target #(.TARGET_ADDR(7'h50)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign bus.SDA = m_low ? 1'b0 : 1'bz;
    assign sda_line = bus.SDA;
    always @(posedge clk) begin
        if (bus.rx_valid) rx_cnt <= rx_cnt + 1;
        if (bus.rd_req) begin
            bus.tx_data <= tx_seq[rd_cnt & 3];
            rd_cnt <= rd_cnt + 1;
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic clock_bit(input logic b, output logic r);
        m_low = !b;
        #Q bus.SCL = 1'b1;
        #Q r = sda_line;
        #Q bus.SCL = 1'b0;
        #Q;
    endtask
    task automatic bus_start;
        m_low = 1'b0;
        #Q bus.SCL = 1'b1;
        #Q m_low = 1'b1;
        #Q bus.SCL = 1'b0;
        #Q;
    endtask
    task automatic bus_stop;
        m_low = 1'b1;
        #Q bus.SCL = 1'b1;
        #Q m_low = 1'b0;
        #Q;
    endtask
    task automatic wr_byte(input logic [7:0] b, output logic a);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, a);
    endtask
    task automatic rd_byte(input logic m_ack, output logic [7:0] d);
        logic [7:0] v;
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            v[i] = r;
        end
        clock_bit(!m_ack, r);
        d = v;
    endtask
    initial begin
        logic a;
        logic r;
        logic [7:0] d;
        int rx0, rd0;
        bus.SCL = 1'b1;
        @(negedge clk);
        #20 m_low = 1'b1;
        #20 bus.SCL = 1'b0;
        #20 rst = 1'b0;
        #100 m_low = 1'b0;
        #Q bus.SCL = 1'b1;
        #Q;
        check("rst_busy", bus.busy, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_sda", sda_line, 1);
        rx0 = rx_cnt;
        bus_start;
        wr_byte(8'hA0, a);
        check("wr_addr_ack", a, 0);
        wr_byte(8'hA5, a);
        check("wr_data_ack", a, 0);
        check("wr_rx_data", bus.rx_data, 8'hA5);
        check("wr_rx_pulses", rx_cnt - rx0, 1);
        check("wr_busy", bus.busy, 1);
        bus_stop;
        check("wr_idle", bus.busy, 0);
        rx0 = rx_cnt;
        bus_start;
        wr_byte(8'hA2, a);
        check("mis_addr_nack", a, 1);
        check("mis_wait_busy", bus.busy, 1);
        wr_byte(8'h55, a);
        check("mis_data_nack", a, 1);
        check("mis_rx_pulses", rx_cnt - rx0, 0);
        bus_stop;
        check("mis_idle", bus.busy, 0);
        rd0 = rd_cnt;
        bus_start;
        wr_byte(8'hA1, a);
        check("rd1_addr_ack", a, 0);
        rd_byte(1'b0, d);
        check("rd1_data", d, 8'h3C);
        check("rd1_req_pulses", rd_cnt - rd0, 1);
        #Q;
        check("rd1_released", sda_line, 1);
        check("rd1_wait_busy", bus.busy, 1);
        bus_stop;
        check("rd1_idle", bus.busy, 0);
        rd0 = rd_cnt;
        bus_start;
        wr_byte(8'hA1, a);
        check("rd2_addr_ack", a, 0);
        rd_byte(1'b1, d);
        check("rd2_byte0", d, 8'h81);
        rd_byte(1'b0, d);
        check("rd2_byte1", d, 8'h7E);
        check("rd2_req_pulses", rd_cnt - rd0, 2);
        check("rd2_wait_busy", bus.busy, 1);
        bus_stop;
        check("rd2_idle", bus.busy, 0);
        rx0 = rx_cnt;
        bus_start;
        wr_byte(8'hA0, a);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, r);
        bus_start;
        check("rs_no_partial", rx_cnt - rx0, 0);
        wr_byte(8'hA0, a);
        check("rs_addr_ack", a, 0);
        wr_byte(8'h5A, a);
        check("rs_data_ack", a, 0);
        check("rs_rx_data", bus.rx_data, 8'h5A);
        check("rs_rx_pulses", rx_cnt - rx0, 1);
        for (int i = 7; i >= 0; i--) clock_bit(i[0], r);
        m_low = 1'b0;
        #Q;
        check("ack_driven", sda_line, 0);
        rst = 1'b1;
        #10;
        check("mid_rst_sda", sda_line, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rx_data", bus.rx_data, 8'h00);
        rst = 1'b0;
        #Q bus_stop;
        check("post_rst_idle", bus.busy, 0);
        bus_start;
        wr_byte(8'hA0, a);
        check("post_rst_ack", a, 0);
        bus_stop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
